bp_fe_queue_enqueuer: RTL and testbench

// - FE-side producer of the FE queue: packs fetched instructions and FE exceptions into fe_queue packets.
// - Fetch messages carry pc, instr and branch_metadata_fwd. Exception messages carry vaddr and exception_code.
// - Buffers packets in a small circular FIFO and delivers them to the BE issue queue over valid/ready.
// - Drops all speculative work on a redirect.
// - Sits between FE PC-gen/icache output and the fe_queue_i/fe_queue_v_i/fe_queue_ready_o port of the BE.

---
 rtl/bp_fe_queue_enqueuer_pkg.sv | 73 +++++++
 rtl/bp_fe_enq_fifo.sv | 58 +++++
 rtl/bp_fe_queue_enqueuer.sv | 87 ++++++++
 tb/tb_bp_fe_queue_enqueuer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_queue_enqueuer_pkg.sv
// Shared FE-queue types: processor config, fe_queue packet layout and the
// enqueuer state encoding.
package bp_fe_queue_enqueuer_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned vaddr_width_gp               = 39;
    localparam int unsigned instr_width_gp               = 32;
    localparam int unsigned branch_metadata_fwd_width_gp = 36;

    function automatic int unsigned vaddr_width_f(input bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

    function automatic int unsigned bmfwd_width_f(input bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return branch_metadata_fwd_width_gp;
            default:          return branch_metadata_fwd_width_gp;
        endcase
    endfunction

    typedef enum logic [0:0] {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef enum logic [1:0] {
        e_instr_misaligned   = 2'd0,
        e_itlb_miss          = 2'd1,
        e_instr_access_fault = 2'd2,
        e_instr_page_fault   = 2'd3
    } bp_fe_exception_code_e;

    typedef struct packed {
        logic [vaddr_width_gp-1:0]               pc;
        logic [instr_width_gp-1:0]               instr;
        logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
    } bp_fe_fetch_s;

    localparam int unsigned fe_msg_width_gp  = $bits(bp_fe_fetch_s);
    localparam int unsigned exc_pad_width_gp =
        fe_msg_width_gp - vaddr_width_gp - $bits(bp_fe_exception_code_e);

    // Padding sits above the payload so both union members share one width.
    typedef struct packed {
        logic [exc_pad_width_gp-1:0] padding;
        logic [vaddr_width_gp-1:0]   vaddr;
        bp_fe_exception_code_e       exception_code;
    } bp_fe_exception_s;

    typedef union packed {
        bp_fe_fetch_s     fetch;
        bp_fe_exception_s exception;
    } bp_fe_queue_msg_u;

    typedef struct packed {
        bp_fe_queue_type_e msg_type;
        bp_fe_queue_msg_u  msg;
    } bp_fe_queue_s;

    localparam int unsigned fe_queue_width_gp = $bits(bp_fe_queue_s);

    typedef enum logic [0:0] {
        e_run      = 1'b0,
        e_exc_wait = 1'b1
    } bp_fe_enq_state_e;

endpackage

// File: rtl/bp_fe_enq_fifo.sv
// Small circular buffer with async reset and synchronous clear; head is
// presented combinationally from storage.
module bp_fe_enq_fifo #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 2,
    localparam int unsigned ptr_w_lp = $clog2(els_p),
    localparam int unsigned cnt_w_lp = ptr_w_lp + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clr_i,
    input  logic                enq_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                deq_i,
    output logic [width_p-1:0]  data_o,
    output logic [cnt_w_lp-1:0] cnt_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q;
    logic [ptr_w_lp-1:0] wptr_q;
    logic [cnt_w_lp-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq_i) wptr_q <= wptr_q + ptr_w_lp'(1);
            if (deq_i) rptr_q <= rptr_q + ptr_w_lp'(1);
            unique case ({enq_i, deq_i})
                2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i && !clr_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o = mem_q[rptr_q];
    assign cnt_o  = cnt_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq_i && (cnt_q == cnt_w_lp'(els_p))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(deq_i && (cnt_q == '0)));
    a_els_pow2: assert property (@(posedge clk_i)
        (els_p >= 2) && ((els_p & (els_p - 1)) == 0));

endmodule

// File: rtl/bp_fe_queue_enqueuer.sv
// FE-side producer of the FE queue: packs fetches/exceptions into fe_queue
// packets, buffers them and stalls after an exception until redirect.
module bp_fe_queue_enqueuer
    import bp_fe_queue_enqueuer_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned els_p       = 2,
    localparam int unsigned vaddr_w_lp = vaddr_width_f(bp_params_p),
    localparam int unsigned bmfwd_w_lp = bmfwd_width_f(bp_params_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          fetch_v_i,
    input  logic [vaddr_w_lp-1:0]         fetch_pc_i,
    input  logic [31:0]                   fetch_instr_i,
    input  logic [bmfwd_w_lp-1:0]         fetch_meta_i,
    input  logic                          exc_v_i,
    input  bp_fe_exception_code_e         exc_code_i,
    input  logic [vaddr_w_lp-1:0]         exc_vaddr_i,
    output logic                          fetch_ready_o,
    input  logic                          redirect_i,
    output logic [fe_queue_width_gp-1:0]  fe_queue_o,
    output logic                          fe_queue_v_o,
    input  logic                          fe_queue_ready_i,
    output logic                          stalled_o
);

    localparam int unsigned cnt_w_lp = $clog2(els_p) + 1;

    bp_fe_enq_state_e              state_q;
    logic                          stalled_q;
    logic [cnt_w_lp-1:0]           cnt;
    logic [fe_queue_width_gp-1:0]  head;
    bp_fe_queue_s                  enq_pkt;
    logic                          accept;
    logic                          deq;

    assign fetch_ready_o = (state_q == e_run) && (cnt != cnt_w_lp'(els_p)) && !redirect_i;
    assign accept        = (fetch_v_i || exc_v_i) && fetch_ready_o;
    assign fe_queue_v_o  = (cnt != '0);
    assign deq           = fe_queue_v_o && fe_queue_ready_i;
    assign fe_queue_o    = fe_queue_v_o ? head : '0;
    assign stalled_o     = stalled_q;

    // Exception wins over a same-cycle fetch; the fetch is dropped.
    always_comb begin
        enq_pkt = '0;
        if (exc_v_i) begin
            enq_pkt.msg_type                     = e_fe_exception;
            enq_pkt.msg.exception.vaddr          = exc_vaddr_i;
            enq_pkt.msg.exception.exception_code = exc_code_i;
        end else begin
            enq_pkt.msg_type                      = e_fe_fetch;
            enq_pkt.msg.fetch.pc                  = fetch_pc_i;
            enq_pkt.msg.fetch.instr               = fetch_instr_i;
            enq_pkt.msg.fetch.branch_metadata_fwd = fetch_meta_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_run;
            stalled_q <= 1'b0;
        end else if (redirect_i) begin
            state_q   <= e_run;
            stalled_q <= 1'b0;
        end else if (accept && exc_v_i) begin
            state_q   <= e_exc_wait;
            stalled_q <= 1'b1;
        end
    end

    bp_fe_enq_fifo #(
        .width_p (fe_queue_width_gp),
        .els_p   (els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (redirect_i),
        .enq_i   (accept),
        .data_i  (enq_pkt),
        .deq_i   (deq),
        .data_o  (head),
        .cnt_o   (cnt)
    );

endmodule

// File: tb/tb_bp_fe_queue_enqueuer.sv
// Scoreboard bench for bp_fe_queue_enqueuer: directed stimulus pushes expected
// packets, an independent monitor pops and compares on every transfer.
module tb_bp_fe_queue_enqueuer;
    import bp_fe_queue_enqueuer_pkg::*;

    localparam int unsigned ELS = 2;

    logic                         clk = 1'b0;
    logic                         reset_i;
    logic                         fetch_v_i;
    logic [38:0]                  fetch_pc_i;
    logic [31:0]                  fetch_instr_i;
    logic [35:0]                  fetch_meta_i;
    logic                         exc_v_i;
    bp_fe_exception_code_e        exc_code_i;
    logic [38:0]                  exc_vaddr_i;
    logic                         fetch_ready_o;
    logic                         redirect_i;
    logic [fe_queue_width_gp-1:0] fe_queue_o;
    logic                         fe_queue_v_o;
    logic                         fe_queue_ready_i;
    logic                         stalled_o;

    int unsigned      vectors     = 0;
    int unsigned      miscompares = 0;
    bp_fe_queue_s     exp_q[$];
    int               mcnt;
    bp_fe_enq_state_e mst;

    always #5 clk = ~clk;

    bp_fe_queue_enqueuer #(
        .bp_params_p (e_bp_default_cfg),
        .els_p       (ELS)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fetch_v_i        (fetch_v_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_instr_i    (fetch_instr_i),
        .fetch_meta_i     (fetch_meta_i),
        .exc_v_i          (exc_v_i),
        .exc_code_i       (exc_code_i),
        .exc_vaddr_i      (exc_vaddr_i),
        .fetch_ready_o    (fetch_ready_o),
        .redirect_i       (redirect_i),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_ready_i (fe_queue_ready_i),
        .stalled_o        (stalled_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [38:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    function automatic logic [35:0] meta_of(input logic [38:0] pc);
        return pc[35:0] ^ 36'hA_5A5A_5A5A;
    endfunction

    function automatic bp_fe_queue_s fetch_pkt(input logic [38:0] pc);
        bp_fe_queue_s p;
        p = '0;
        p.msg_type                      = e_fe_fetch;
        p.msg.fetch.pc                  = pc;
        p.msg.fetch.instr               = instr_of(pc);
        p.msg.fetch.branch_metadata_fwd = meta_of(pc);
        return p;
    endfunction

    function automatic bp_fe_queue_s exc_pkt(input bp_fe_exception_code_e code, input logic [38:0] va);
        bp_fe_queue_s p;
        p = '0;
        p.msg_type                     = e_fe_exception;
        p.msg.exception.vaddr          = va;
        p.msg.exception.exception_code = code;
        return p;
    endfunction

    always @(negedge clk) begin
        if (!reset_i && fe_queue_v_o && fe_queue_ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pkt: got unexpected packet %h, expected none", fe_queue_o);
            end else begin
                chk("pkt", 128'(fe_queue_o), 128'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive at posedge+1, check at posedge+3, advance model at posedge.
    task automatic step(input logic fv, input logic [38:0] pc, input logic ev,
                        input bp_fe_exception_code_e code, input logic [38:0] va,
                        input logic rdy, input logic redir, output logic acc);
        logic exp_rdy;
        logic deq;
        fetch_v_i        = fv;
        fetch_pc_i       = pc;
        fetch_instr_i    = instr_of(pc);
        fetch_meta_i     = meta_of(pc);
        exc_v_i          = ev;
        exc_code_i       = code;
        exc_vaddr_i      = va;
        fe_queue_ready_i = rdy;
        redirect_i       = redir;
        #2;
        exp_rdy = (mst == e_run) && (mcnt != ELS) && !redir;
        chk("fetch_ready", 128'(fetch_ready_o), 128'(exp_rdy));
        chk("v_o", 128'(fe_queue_v_o), 128'(mcnt != 0));
        chk("stalled", 128'(stalled_o), 128'(mst == e_exc_wait));
        if (mcnt != 0 && exp_q.size() != 0) chk("head", 128'(fe_queue_o), 128'(exp_q[0]));
        acc = exp_rdy && (fv || ev);
        if (acc) exp_q.push_back(ev ? exc_pkt(code, va) : fetch_pkt(pc));
        deq = (mcnt != 0) && rdy;
        @(posedge clk);
        if (redir) begin
            mcnt = 0;
            mst  = e_run;
            exp_q.delete();
        end else begin
            mcnt = mcnt + (acc ? 1 : 0) - (deq ? 1 : 0);
            if (acc && ev) mst = e_exc_wait;
        end
        #1;
    endtask

    task automatic fetch(input logic [38:0] pc, input logic rdy, output logic acc);
        step(1'b1, pc, 1'b0, e_instr_misaligned, '0, rdy, 1'b0, acc);
    endtask

    task automatic idle(input logic rdy, input logic redir);
        logic acc;
        step(1'b0, '0, 1'b0, e_instr_misaligned, '0, rdy, redir, acc);
    endtask

    initial begin
        logic        acc;
        int unsigned n;
        int unsigned guard;
        reset_i          = 1'b1;
        fetch_v_i        = 1'b0;
        fetch_pc_i       = '0;
        fetch_instr_i    = '0;
        fetch_meta_i     = '0;
        exc_v_i          = 1'b0;
        exc_code_i       = e_instr_misaligned;
        exc_vaddr_i      = '0;
        redirect_i       = 1'b0;
        fe_queue_ready_i = 1'b0;
        mcnt             = 0;
        mst              = e_run;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", 128'(fe_queue_v_o), 128'(0));
        chk("rst_pkt", 128'(fe_queue_o), 128'(0));
        chk("rst_stalled", 128'(stalled_o), 128'(0));
        reset_i = 1'b0;

        // back-to-back fetches with ready high
        for (int i = 0; i < 3; i++) fetch(39'h00_8000_0000 + 39'(4 * i), 1'b1, acc);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // backpressure: third fetch must be refused at cnt==2
        fetch(39'h00_8000_0100, 1'b0, acc);
        chk("bp_acc0", 128'(acc), 128'(1));
        fetch(39'h00_8000_0104, 1'b0, acc);
        chk("bp_acc1", 128'(acc), 128'(1));
        fetch(39'h00_8000_0108, 1'b0, acc);
        chk("bp_acc2", 128'(acc), 128'(0));
        idle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

        // exception with simultaneous fetch, stall until redirect
        step(1'b1, 39'h00_8000_0200, 1'b1, e_itlb_miss, 39'h00_8000_1000, 1'b1, 1'b0, acc);
        chk("exc_acc", 128'(acc), 128'(1));
        for (int i = 0; i < 3; i++) begin
            fetch(39'h00_8000_0204, 1'b1, acc);
            chk("exc_blocked", 128'(acc), 128'(0));
        end
        step(1'b1, 39'h00_8000_0204, 1'b0, e_instr_misaligned, '0, 1'b1, 1'b1, acc);
        chk("redir_acc", 128'(acc), 128'(0));
        idle(1'b1, 1'b0);

        // redirect with cnt==2 and a transfer in the same cycle
        fetch(39'h00_8000_0300, 1'b0, acc);
        fetch(39'h00_8000_0304, 1'b0, acc);
        step(1'b1, 39'h00_8000_0308, 1'b0, e_instr_misaligned, '0, 1'b1, 1'b1, acc);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // asynchronous reset with two packets buffered
        fetch(39'h00_8000_0400, 1'b0, acc);
        fetch(39'h00_8000_0404, 1'b0, acc);
        fetch_v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_v", 128'(fe_queue_v_o), 128'(0));
        chk("async_rst_pkt", 128'(fe_queue_o), 128'(0));
        exp_q.delete();
        mcnt = 0;
        mst  = e_run;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        idle(1'b0, 1'b0);

        // wrap-around with random ready
        n     = 0;
        guard = 0;
        while (n < 10 && guard < 200) begin
            fetch(39'h00_8000_0500 + 39'(4 * n), 1'($urandom_range(0, 1)), acc);
            if (acc) n++;
            guard++;
        end
        chk("wrap_accepted", 128'(n), 128'(10));
        guard = 0;
        while (mcnt != 0 && guard < 20) begin
            idle(1'b1, 1'b0);
            guard++;
        end
        idle(1'b1, 1'b0);
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
